// File: rtl/kfmmc_card_cmd_responder.sv
// Card-side responder for the single-bit MMC/SD command line.
// Receives 48-bit host commands (framing + CRC7 check) and serialises
// R1/R3 (48-bit) or R2 (136-bit) responses back onto the command line.
// All logic runs on `clock`; mmc_clk and the command line are oversampled.

module kfmmc_card_cmd_responder #(
  parameter logic [7:0] ncr_cycles = 8'd2
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         mmc_clk,
  input  logic         mmc_cmd_in,
  output logic         mmc_cmd_out,
  output logic         mmc_cmd_oe,
  output logic         command_valid,
  output logic         command_crc_error,
  output logic [5:0]   command_index,
  output logic [31:0]  command_argument,
  input  logic         response_start,
  input  logic         response_long,
  input  logic         response_crc_enable,
  input  logic [135:0] response_data,
  output logic         response_done,
  output logic         busy
);

  typedef enum logic [2:0] {
    StIdle,
    StReceive,
    StCheck,
    StWait,
    StNcr,
    StSend
  } state_e;

  // Serial CRC7, polynomial x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = crc[6] ^ din;
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // Synchroniser state
  logic mclk_meta_q, mclk_sync_q, mclk_prev_q;
  logic cmd_meta_q, cmd_sync_q;
  logic clk_rise, clk_fall;

  // Receive path
  state_e       state_q;
  logic [47:0]  rx_shift_q;
  logic [5:0]   rx_cnt_q;
  logic [6:0]   rx_crc_q;

  // Transmit path
  logic [135:0] tx_data_q;
  logic         tx_long_q;
  logic         tx_crc_en_q;
  logic [7:0]   tx_pos_q;
  logic [6:0]   tx_crc_q;
  logic [7:0]   ncr_cnt_q;
  logic         done_pend_q;

  logic [7:0]   tx_top;
  logic [7:0]   tx_next_pos;
  logic         tx_last;
  logic         tx_bit;
  logic         tx_crc_cover;

  // Two-flop synchronisers for mmc_clk and the command line, plus edge history.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mclk_meta_q <= 1'b0;
      mclk_sync_q <= 1'b0;
      mclk_prev_q <= 1'b0;
      cmd_meta_q  <= 1'b1;
      cmd_sync_q  <= 1'b1;
    end else begin
      mclk_meta_q <= mmc_clk;
      mclk_sync_q <= mclk_meta_q;
      mclk_prev_q <= mclk_sync_q;
      cmd_meta_q  <= mmc_cmd_in;
      cmd_sync_q  <= cmd_meta_q;
    end
  end

  assign clk_rise = mclk_sync_q & ~mclk_prev_q;
  assign clk_fall = ~mclk_sync_q & mclk_prev_q;

  // Next transmit bit: position, CRC substitution and CRC coverage window.
  always_comb begin
    tx_top       = tx_long_q ? 8'd135 : 8'd47;
    tx_next_pos  = mmc_cmd_oe ? (tx_pos_q - 8'd1) : tx_top;
    tx_last      = mmc_cmd_oe && (tx_pos_q == 8'd0);
    tx_bit       = tx_data_q[tx_next_pos];
    tx_crc_cover = (tx_next_pos >= 8'd8) && (!tx_long_q || (tx_next_pos <= 8'd127));
    if (tx_crc_en_q) begin
      if ((tx_next_pos >= 8'd1) && (tx_next_pos <= 8'd7)) begin
        tx_bit = tx_crc_q[tx_next_pos[2:0] - 3'd1];
      end else if (tx_next_pos == 8'd0) begin
        // A generated CRC always closes with a proper end bit.
        tx_bit = 1'b1;
      end
    end
  end

  // Main FSM with registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= StIdle;
      rx_shift_q        <= 48'd0;
      rx_cnt_q          <= 6'd0;
      rx_crc_q          <= 7'd0;
      tx_data_q         <= 136'd0;
      tx_long_q         <= 1'b0;
      tx_crc_en_q       <= 1'b0;
      tx_pos_q          <= 8'd0;
      tx_crc_q          <= 7'd0;
      ncr_cnt_q         <= 8'd0;
      done_pend_q       <= 1'b0;
      mmc_cmd_out       <= 1'b1;
      mmc_cmd_oe        <= 1'b0;
      command_valid     <= 1'b0;
      command_crc_error <= 1'b0;
      command_index     <= 6'd0;
      command_argument  <= 32'd0;
      response_done     <= 1'b0;
      busy              <= 1'b0;
    end else begin
      command_valid     <= 1'b0;
      command_crc_error <= 1'b0;
      // Done and busy-clear trail the release fall by one clock.
      response_done     <= done_pend_q;
      done_pend_q       <= 1'b0;
      if (done_pend_q) begin
        busy <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (clk_rise && !cmd_sync_q) begin
            // Start bit is frame bit 47 (0); CRC of a leading 0 from reset is 0.
            rx_shift_q <= 48'd0;
            rx_cnt_q   <= 6'd1;
            rx_crc_q   <= 7'd0;
            state_q    <= StReceive;
          end
        end

        StReceive: begin
          if (clk_rise) begin
            rx_shift_q <= {rx_shift_q[46:0], cmd_sync_q};
            // Stream positions 0..39 are frame bits 47..8.
            if (rx_cnt_q < 6'd40) begin
              rx_crc_q <= crc7_step(rx_crc_q, cmd_sync_q);
            end
            rx_cnt_q <= rx_cnt_q + 6'd1;
            if (rx_cnt_q == 6'd47) begin
              state_q <= StCheck;
            end
          end
        end

        StCheck: begin
          if ((rx_crc_q == rx_shift_q[7:1]) && rx_shift_q[46] && rx_shift_q[0]) begin
            command_valid    <= 1'b1;
            command_index    <= rx_shift_q[45:40];
            command_argument <= rx_shift_q[39:8];
            state_q          <= StWait;
          end else begin
            command_crc_error <= 1'b1;
            state_q           <= StIdle;
          end
        end

        StWait: begin
          if (response_start) begin
            tx_data_q   <= response_data;
            tx_long_q   <= response_long;
            tx_crc_en_q <= response_crc_enable;
            tx_pos_q    <= 8'd0;
            tx_crc_q    <= 7'd0;
            ncr_cnt_q   <= 8'd0;
            busy        <= 1'b1;
            state_q     <= StNcr;
          end else if (clk_rise && !cmd_sync_q) begin
            // Host moved on without asking for a response.
            rx_shift_q <= 48'd0;
            rx_cnt_q   <= 6'd1;
            rx_crc_q   <= 7'd0;
            state_q    <= StReceive;
          end
        end

        StNcr: begin
          if (clk_fall) begin
            if (ncr_cnt_q == (ncr_cycles - 8'd1)) begin
              state_q <= StSend;
            end else begin
              ncr_cnt_q <= ncr_cnt_q + 8'd1;
            end
          end
        end

        StSend: begin
          if (clk_fall) begin
            if (tx_last) begin
              mmc_cmd_oe  <= 1'b0;
              mmc_cmd_out <= 1'b1;
              done_pend_q <= 1'b1;
              state_q     <= StIdle;
            end else begin
              mmc_cmd_oe  <= 1'b1;
              mmc_cmd_out <= tx_bit;
              tx_pos_q    <= tx_next_pos;
              if (tx_crc_cover) begin
                tx_crc_q <= crc7_step(tx_crc_q, tx_bit);
              end
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_kfmmc_card_cmd_responder.sv
// Scoreboard bench for kfmmc_card_cmd_responder: stimulus pushes expected
// command pulses, response frames and done pulses; monitors pop and compare.

module tb_kfmmc_card_cmd_responder;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         mmc_clk = 1'b0;
  logic         host_oe = 1'b0;
  logic         host_bit = 1'b1;
  logic         mmc_cmd_in;
  logic         mmc_cmd_out;
  logic         mmc_cmd_oe;
  logic         command_valid;
  logic         command_crc_error;
  logic [5:0]   command_index;
  logic [31:0]  command_argument;
  logic         response_start = 1'b0;
  logic         response_long = 1'b0;
  logic         response_crc_enable = 1'b0;
  logic [135:0] response_data = '0;
  logic         response_done;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        valid;
    logic [5:0]  idx;
    logic [31:0] arg;
  } cmd_exp_t;

  typedef struct {
    int           len;
    logic [135:0] data;
  } resp_exp_t;

  cmd_exp_t  cmd_q[$];
  resp_exp_t resp_q[$];
  int        done_q[$];

  localparam logic [47:0]  Cmd0     = 48'h40_0000_0000_95;
  localparam logic [47:0]  Cmd8     = 48'h48_0000_01AA_87;
  localparam logic [47:0]  Cmd8Bad  = 48'h48_0000_01AA_86;
  localparam logic [47:0]  Cmd55    = 48'h77_0000_0000_65;
  localparam logic [135:0] LongPat  = 136'h3F_0123456789ABCDEF_FEDCBA98765432_FF;

  assign mmc_cmd_in = host_oe ? host_bit : (mmc_cmd_oe ? mmc_cmd_out : 1'b1);

  always #5 clock = ~clock;
  always #40 mmc_clk = ~mmc_clk;

  kfmmc_card_cmd_responder #(.ncr_cycles(8'd2)) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .mmc_clk            (mmc_clk),
    .mmc_cmd_in         (mmc_cmd_in),
    .mmc_cmd_out        (mmc_cmd_out),
    .mmc_cmd_oe         (mmc_cmd_oe),
    .command_valid      (command_valid),
    .command_crc_error  (command_crc_error),
    .command_index      (command_index),
    .command_argument   (command_argument),
    .response_start     (response_start),
    .response_long      (response_long),
    .response_crc_enable(response_crc_enable),
    .response_data      (response_data),
    .response_done      (response_done),
    .busy               (busy)
  );

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic expect_cmd(input logic valid, input logic [5:0] idx, input logic [31:0] arg);
    cmd_exp_t e;
    e.valid = valid;
    e.idx   = idx;
    e.arg   = arg;
    cmd_q.push_back(e);
  endtask

  task automatic expect_resp(input int len, input logic [135:0] data);
    resp_exp_t r;
    r.len  = len;
    r.data = data;
    resp_q.push_back(r);
    done_q.push_back(1);
  endtask

  // Host drives on mmc_clk falls; the card samples on rises.
  task automatic send_frame(input logic [47:0] f);
    @(negedge mmc_clk);
    host_oe = 1'b1;
    for (int i = 47; i >= 0; i--) begin
      host_bit = f[i];
      @(negedge mmc_clk);
    end
    host_oe  = 1'b0;
    host_bit = 1'b1;
  endtask

  task automatic pulse_start(input logic lng, input logic crc, input logic [135:0] data);
    @(negedge clock);
    response_long       = lng;
    response_crc_enable = crc;
    response_data       = data;
    response_start      = 1'b1;
    @(negedge clock);
    response_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check(name, 136'(busy), 136'(0));
  endtask

  // Command monitor
  always @(negedge clock) begin
    cmd_exp_t e;
    if (reset_n && (command_valid || command_crc_error)) begin
      if (cmd_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL cmd_unexpected: valid %b err %b idx %0d", command_valid,
                 command_crc_error, command_index);
      end else begin
        e = cmd_q.pop_front();
        check("cmd_kind", 136'({command_valid, command_crc_error}), 136'({e.valid, !e.valid}));
        check("cmd_index", 136'(command_index), 136'(e.idx));
        check("cmd_argument", 136'(command_argument), 136'(e.arg));
      end
    end
  end

  // Response line monitor: host samples on mmc_clk rise
  logic [135:0] cap = '0;
  int           cap_n = 0;
  always @(posedge mmc_clk) begin
    resp_exp_t r;
    if (!reset_n) begin
      cap_n = 0;
    end else if (mmc_cmd_oe) begin
      if (cap_n == 0) cap = '0;
      cap = {cap[134:0], mmc_cmd_out};
      cap_n++;
    end else if (cap_n != 0) begin
      if (resp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL resp_unexpected: %0d bits %h", cap_n, cap);
      end else begin
        r = resp_q.pop_front();
        check("resp_length", 136'(cap_n), 136'(r.len));
        check("resp_data", cap, r.data);
      end
      cap_n = 0;
    end
  end

  // Done monitor: done must follow oe release by exactly one clock
  logic [1:0] oe_hist = 2'b00;
  always @(negedge clock) begin
    if (reset_n && response_done) begin
      if (done_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL done_unexpected: response_done 1 required 0");
      end else begin
        void'(done_q.pop_front());
        check("done_after_release", 136'(oe_hist), 136'(2'b10));
        check("busy_at_done", 136'(busy), 136'(0));
      end
    end
    oe_hist = {oe_hist[0], mmc_cmd_oe};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic bad;

    #23;
    check("rst_cmd_out", 136'(mmc_cmd_out), 136'(1));
    check("rst_cmd_oe", 136'(mmc_cmd_oe), 136'(0));
    check("rst_valid", 136'(command_valid), 136'(0));
    check("rst_crc_error", 136'(command_crc_error), 136'(0));
    check("rst_index", 136'(command_index), 136'(0));
    check("rst_argument", 136'(command_argument), 136'(0));
    check("rst_done", 136'(response_done), 136'(0));
    check("rst_busy", 136'(busy), 136'(0));
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);

    // CMD0, then a corrupted CMD8 (index/argument must hold), then good CMD8
    expect_cmd(1'b1, 6'd0, 32'd0);
    send_frame(Cmd0);
    expect_cmd(1'b0, 6'd0, 32'd0);
    send_frame(Cmd8Bad);
    expect_cmd(1'b1, 6'd8, 32'h0000_01AA);
    send_frame(Cmd8);

    // Short response with generated CRC; start bit on the third fall
    expect_resp(48, 136'(48'h40_0000_0000_95));
    pulse_start(1'b0, 1'b1, 136'(48'h40_0000_0000_00));
    @(negedge mmc_clk);
    #35;
    check("ncr_quiet_oe", 136'(mmc_cmd_oe), 136'(0));
    @(negedge mmc_clk);
    #35;
    check("start_bit_oe", 136'(mmc_cmd_oe), 136'(1));
    check("start_bit_val", 136'(mmc_cmd_out), 136'(0));
    wait_idle("short_resp_busy_clear");

    // CMD0 then CMD55 while waiting, then a verbatim long response
    expect_cmd(1'b1, 6'd0, 32'd0);
    send_frame(Cmd0);
    expect_cmd(1'b1, 6'd55, 32'd0);
    send_frame(Cmd55);
    expect_resp(136, LongPat);
    pulse_start(1'b1, 1'b0, LongPat);
    wait_idle("long_resp_busy_clear");

    // response_start while idle must be ignored
    repeat (20) @(negedge clock);
    pulse_start(1'b0, 1'b1, 136'(48'h40_0000_0000_00));
    bad = 1'b0;
    repeat (400) begin
      @(negedge clock);
      if (busy || mmc_cmd_oe) bad = 1'b1;
    end
    check("idle_start_ignored", 136'(bad), 136'(0));

    // Reset during the 20th response bit
    expect_cmd(1'b1, 6'd8, 32'h0000_01AA);
    send_frame(Cmd8);
    pulse_start(1'b0, 1'b1, 136'(48'h40_0000_0000_00));
    n = 0;
    while (!mmc_cmd_oe && n < 500) begin
      @(negedge clock);
      n++;
    end
    check("abort_resp_oe_rise", 136'(mmc_cmd_oe), 136'(1));
    repeat (19) @(negedge mmc_clk);
    #35;
    reset_n = 1'b0;
    #1;
    check("async_rst_oe", 136'(mmc_cmd_oe), 136'(0));
    check("async_rst_out", 136'(mmc_cmd_out), 136'(1));
    check("async_rst_busy", 136'(busy), 136'(0));
    #200;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);

    expect_cmd(1'b1, 6'd0, 32'd0);
    send_frame(Cmd0);
    repeat (200) @(negedge clock);

    check("cmd_queue_drained", 136'(cmd_q.size()), 136'(0));
    check("resp_queue_drained", 136'(resp_q.size()), 136'(0));
    check("done_queue_drained", 136'(done_q.size()), 136'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
